// File: rtl/coproc_host_sequencer_if.sv
// coproc_host_sequencer_if -- host command/payload/read-return signals plus the
// controller instruct/out pins of the coprocessor host sequencer, bundled as one bus.
interface coproc_host_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_sel;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_last;
    logic [31:0] rd_data;
    logic        cmd_done;
    logic        cmd_err;
    logic [31:0] coproc_instr;
    logic [31:0] coproc_out;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, wr_valid, wr_data, coproc_out,
        output cmd_ready, wr_ready, rd_valid, rd_last, rd_data, cmd_done, cmd_err, coproc_instr
    );

    // Host / controller side
    modport master (
        output cmd_valid, cmd_op, cmd_sel, wr_valid, wr_data, coproc_out,
        input  cmd_ready, wr_ready, rd_valid, rd_last, rd_data, cmd_done, cmd_err, coproc_instr
    );
endinterface

// File: rtl/coproc_host_sequencer.sv
// coproc_host_sequencer -- host-side initiator for the coprocessor 32-bit instruction port.
// Accepts one read/write/key-load command, buffers write payload, emits the
// PRESEL/HEADER/BURST/NOP word stream and returns read words to the host.
// Optional feature: define SEQ_ILLEGAL_CHECK_EN to reject op 2'b11 and key selects
// above 5 with a one-cycle cmd_err pulse instead of issuing them.
module coproc_host_sequencer #(
    parameter int          MAX_WORDS = 14,
    parameter logic [31:0] NOP_WORD  = 32'hC000_0000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    coproc_host_sequencer_if.slave bus
);
    localparam int         IDX_W    = $clog2(MAX_WORDS);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_KEY   = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PRESEL = 3'd2,
        ST_HEADER = 3'd3,
        ST_BURST  = 3'd4,
        ST_WAIT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Transfer length the controller uses for a given op/select.
    function automatic logic [5:0] word_count(input logic [1:0] op, input logic [3:0] sel);
        logic [5:0] n;
        n = 6'd1;
        case (op)
            OP_READ, OP_WRITE: begin
                case (sel)
                    4'd0, 4'd1, 4'd2, 4'd8, 4'd9: n = 6'd4;
                    4'd5, 4'd6:                   n = 6'd8;
                    4'd12, 4'd13, 4'd14:          n = 6'd5;
                    4'd4:                         n = 6'd14;
                    4'd7:                         n = 6'd3;
                    default:                      n = 6'd1;
                endcase
            end
            OP_KEY: begin
                case (sel)
                    4'd0, 4'd1:       n = 6'd4;
                    4'd2:             n = 6'd5;
                    4'd3, 4'd4, 4'd5: n = 6'd32;
                    default:          n = 6'd1;
                endcase
            end
            default: n = 6'd1;
        endcase
        return n;
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  op_r;
    logic [3:0]  sel_r;
    logic [5:0]  n_r;
    logic [5:0]  cnt_r;
    logic [31:0] wbuf_r [MAX_WORDS];
    logic [31:0] instr_r;
    logic        cmd_ready_r, wr_ready_r, cmd_done_r, cmd_err_r;
    logic        rd_valid_r, rd_last_r;
    logic [31:0] rd_data_r;

    logic        accept_s, reject_s, wr_take_s, illegal_s, rd_sample_s;
    logic [1:0]  op_s;
    logic [3:0]  sel_s;
    logic [5:0]  last_cnt_s;
    logic [31:0] burst_word_s, instr_s;

`ifdef SEQ_ILLEGAL_CHECK_EN
    // Op 11 and key selects without a key slot are refused at the door.
    always_comb begin
        illegal_s = 1'b0;
        if (bus.cmd_op == OP_NOP) begin
            illegal_s = 1'b1;
        end else if ((bus.cmd_op == OP_KEY) && (bus.cmd_sel > 4'd5)) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
    end
`else
    assign illegal_s = 1'b0;
`endif

    // Header/PRESEL use the live command on the accept edge, the latched one afterwards.
    always_comb begin
        op_s  = op_r;
        sel_s = sel_r;
        if (state_r == ST_IDLE) begin
            op_s  = bus.cmd_op;
            sel_s = bus.cmd_sel;
        end else begin
            op_s  = op_r;
            sel_s = sel_r;
        end
    end

    // Cycle (relative to HEADER) on which WAIT hands over to DONE.
    always_comb begin
        last_cnt_s = n_r + 6'd1;
        if (op_r == OP_WRITE) begin
            last_cnt_s = n_r + 6'd2;
        end else begin
            last_cnt_s = n_r + 6'd1;
        end
    end

    // Payload word for the next BURST cycle; out-of-range counts fall back to NOP.
    always_comb begin
        burst_word_s = NOP_WORD;
        if (cnt_r < 6'(MAX_WORDS)) begin
            burst_word_s = wbuf_r[cnt_r[IDX_W-1:0]];
        end else begin
            burst_word_s = NOP_WORD;
        end
    end

    // Read words appear on coproc_out two to N+1 cycles after HEADER.
    assign rd_sample_s = (state_r == ST_WAIT) && (op_r == OP_READ) &&
                         (cnt_r >= 6'd2) && (cnt_r <= (n_r + 6'd1));

    // Next-state logic and handshake strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        reject_s  = 1'b0;
        wr_take_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_r) begin
                    if (illegal_s) begin
                        reject_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        accept_s = 1'b1;
                        case (bus.cmd_op)
                            OP_WRITE:        state_s = ST_LOAD;
                            OP_READ, OP_KEY: state_s = ST_PRESEL;
                            default:         state_s = ST_HEADER;
                        endcase
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.wr_valid && wr_ready_r) begin
                    wr_take_s = 1'b1;
                    if (cnt_r == (n_r - 6'd1)) begin
                        state_s = ST_PRESEL;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_PRESEL: state_s = ST_HEADER;
            ST_HEADER: begin
                if (op_r == OP_WRITE) begin
                    state_s = ST_BURST;
                end else if (op_r == OP_NOP) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_BURST: begin
                if (cnt_r == n_r) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_BURST;
                end
            end
            ST_WAIT: begin
                if (cnt_r == last_cnt_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Instruction word for the coming cycle, chosen from the state being entered.
    always_comb begin
        instr_s = NOP_WORD;
        case (state_s)
            ST_PRESEL: instr_s = {2'b11, 26'd0, sel_s};
            ST_HEADER: instr_s = {op_s, 26'd0, sel_s};
            ST_BURST:  instr_s = burst_word_s;
            default:   instr_s = NOP_WORD;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch op, select and transfer length when a command is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_r  <= 2'b00;
            sel_r <= 4'd0;
            n_r   <= 6'd0;
        end else if (accept_s) begin
            op_r  <= bus.cmd_op;
            sel_r <= bus.cmd_sel;
            n_r   <= word_count(bus.cmd_op, bus.cmd_sel);
        end
    end

    // Shared counter: payload index in LOAD, cycles since HEADER from HEADER onwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 6'd0;
        end else if (accept_s || (state_s == ST_HEADER)) begin
            cnt_r <= 6'd0;
        end else if (wr_take_s) begin
            cnt_r <= cnt_r + 6'd1;
        end else if ((state_r == ST_HEADER) || (state_r == ST_BURST) || (state_r == ST_WAIT)) begin
            cnt_r <= cnt_r + 6'd1;
        end
    end

    // Write payload buffer; cleared on reset so an aborted command leaves nothing behind.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
                wbuf_r[i] <= 32'd0;
            end
        end else if (wr_take_s) begin
            wbuf_r[cnt_r[IDX_W-1:0]] <= bus.wr_data;
        end
    end

    // Registered handshake, status and instruction outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_r <= 1'b0;
            wr_ready_r  <= 1'b0;
            cmd_done_r  <= 1'b0;
            cmd_err_r   <= 1'b0;
            instr_r     <= NOP_WORD;
        end else begin
            cmd_ready_r <= (state_s == ST_IDLE);
            wr_ready_r  <= (state_s == ST_LOAD);
            cmd_done_r  <= (state_s == ST_DONE);
            cmd_err_r   <= reject_s;
            instr_r     <= instr_s;
        end
    end

    // Read return: capture controller output and flag the final word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_data_r  <= 32'd0;
        end else begin
            rd_valid_r <= rd_sample_s;
            rd_last_r  <= rd_sample_s && (cnt_r == (n_r + 6'd1));
            if (rd_sample_s) begin
                rd_data_r <= bus.coproc_out;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready_r;
    assign bus.wr_ready     = wr_ready_r;
    assign bus.cmd_done     = cmd_done_r;
    assign bus.cmd_err      = cmd_err_r;
    assign bus.coproc_instr = instr_r;
    assign bus.rd_valid     = rd_valid_r;
    assign bus.rd_last      = rd_last_r;
    assign bus.rd_data      = rd_data_r;
endmodule

// File: tb/tb_coproc_host_sequencer.sv
// tb_coproc_host_sequencer -- directed vectors for coproc_host_sequencer with a small
// controller model that serves read data and captures write bursts.
module tb_coproc_host_sequencer;
    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    coproc_host_sequencer_if bus();

    coproc_host_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running cycle count used to make idle controller output unique each cycle.
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  sel;
        int          n;
        int          done_off;
        logic [31:0] header;
        bit          gaps;
    } vec_t;

    vec_t vecs [11];

    function automatic int tb_n(input logic [1:0] op, input logic [3:0] sel);
        if (op == 2'b10) begin
            if (sel <= 4'd1) return 4;
            if (sel == 4'd2) return 5;
            if (sel <= 4'd5) return 32;
            return 1;
        end
        case (sel)
            4'd0, 4'd1, 4'd2, 4'd8, 4'd9: return 4;
            4'd5, 4'd6:                   return 8;
            4'd12, 4'd13, 4'd14:          return 5;
            4'd4:                         return 14;
            4'd7:                         return 3;
            default:                      return 1;
        endcase
    endfunction

    function automatic logic [31:0] pay(input logic [3:0] sel, input int idx);
        return {8'h5A, 4'h0, sel, 8'(idx * 7 + 1), 8'(idx)};
    endfunction

    // Controller model: latches select from idle words, serves reads, captures writes.
    logic [31:0] m_mem [16][14];
    int          m_rd_i, m_rd_n, m_wr_i, m_wr_n;
    logic [3:0]  m_lat_sel, m_sel;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 16; s++) begin
                for (int i = 0; i < 14; i++) begin
                    m_mem[s][i] <= {8'hD0, 4'(s), 4'h0, 8'(i), 8'h3C};
                end
            end
            m_rd_i <= -1; m_rd_n <= 0; m_wr_i <= -1; m_wr_n <= 0;
            m_lat_sel <= 4'd0; m_sel <= 4'd0;
            bus.coproc_out <= 32'd0;
        end else begin
            bus.coproc_out <= {16'hBAD0, cyc[15:0]};
            if (m_wr_i >= 0) begin
                if (m_wr_i < 14) m_mem[m_sel][m_wr_i[3:0]] <= bus.coproc_instr;
                if (m_wr_i + 1 >= m_wr_n) m_wr_i <= -1;
                else m_wr_i <= m_wr_i + 1;
            end else if (m_rd_i >= 0) begin
                if (m_rd_i < m_rd_n) begin
                    bus.coproc_out <= m_mem[m_sel][m_rd_i[3:0]];
                    m_rd_i <= m_rd_i + 1;
                end else begin
                    m_rd_i <= -1;
                end
            end else begin
                case (bus.coproc_instr[31:30])
                    2'b11: m_lat_sel <= bus.coproc_instr[3:0];
                    2'b00: begin
                        m_sel <= bus.coproc_instr[3:0];
                        m_rd_n <= tb_n(2'b00, m_lat_sel);
                        m_rd_i <= 0;
                    end
                    2'b01: begin
                        m_sel <= bus.coproc_instr[3:0];
                        m_wr_n <= tb_n(2'b01, m_lat_sel);
                        m_wr_i <= 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Issue one command from an IDLE negedge and check the full word stream; returns at the
    // negedge of the IDLE cycle after DONE so the next call can go back-to-back.
    task automatic run_cmd(input int id, input logic [1:0] op, input logic [3:0] sel, input int n,
                           input int done_off, input logic [31:0] header, input bit gaps);
        int guard, idx, k, done_k, rd_cnt, last_k, bad_nop, bad_ready, bad_rdt;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check($sformatf("v%0d_ready_wait", id), 32'(guard), 32'd0);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_sel = sel;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        if (op == 2'b01) begin
            idx = 0; k = 0;
            while (idx < n && k < 200) begin
                if (gaps && (k % 3 == 2)) begin
                    bus.wr_valid = 1'b0;
                end else begin
                    bus.wr_valid = 1'b1;
                    bus.wr_data  = pay(sel, idx);
                end
                if (bus.wr_valid && bus.wr_ready) idx++;
                @(negedge clock);
                k++;
            end
            bus.wr_valid = 1'b0;
            check($sformatf("v%0d_loaded", id), 32'(idx), 32'(n));
        end
        check($sformatf("v%0d_presel", id), bus.coproc_instr, {2'b11, 26'd0, sel});
        check($sformatf("v%0d_busy_ready", id), {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clock);
        check($sformatf("v%0d_header", id), bus.coproc_instr, header);
        done_k = -1; rd_cnt = 0; last_k = -1; bad_nop = 0; bad_ready = 0; bad_rdt = 0;
        for (k = 1; (k <= done_off + 4) && (done_k < 0); k++) begin
            @(negedge clock);
            if (op == 2'b01 && k <= n) begin
                check($sformatf("v%0d_burst%0d", id, k - 1), bus.coproc_instr, pay(sel, k - 1));
            end else if (bus.coproc_instr !== 32'hC000_0000) begin
                bad_nop++;
            end
            if (bus.rd_valid === 1'b1) begin
                if (rd_cnt < 14) begin
                    check($sformatf("v%0d_rd%0d", id, rd_cnt), bus.rd_data, m_mem[sel][rd_cnt[3:0]]);
                end
                if (k != rd_cnt + 3) bad_rdt++;
                if (bus.rd_last === 1'b1) last_k = k;
                rd_cnt++;
            end
            if (bus.cmd_done === 1'b1) done_k = k;
            else if (bus.cmd_ready !== 1'b0) bad_ready++;
        end
        check($sformatf("v%0d_done_cycle", id), 32'(done_k), 32'(done_off));
        check($sformatf("v%0d_rd_count", id), 32'(rd_cnt), (op == 2'b00) ? 32'(n) : 32'd0);
        check($sformatf("v%0d_rd_last_cycle", id), 32'(last_k), (op == 2'b00) ? 32'(n + 2) : 32'hFFFF_FFFF);
        check($sformatf("v%0d_rd_timing", id), 32'(bad_rdt), 32'd0);
        check($sformatf("v%0d_nop_cycles", id), 32'(bad_nop), 32'd0);
        check($sformatf("v%0d_ready_low", id), 32'(bad_ready), 32'd0);
        @(negedge clock);
        check($sformatf("v%0d_done_pulse", id), {31'd0, bus.cmd_done}, 32'd0);
        check($sformatf("v%0d_idle_ready", id), {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    // Safety net so the bench always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        n_cmp = 0; n_fail = 0; cyc = 0;
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_sel = 4'd0;
        bus.wr_valid = 1'b0; bus.wr_data = 32'd0;

        vecs[0]  = '{2'b00, 4'd7,  3,  5,  32'h0000_0007, 1'b0};
        vecs[1]  = '{2'b01, 4'd4,  14, 17, 32'h4000_0004, 1'b1};
        vecs[2]  = '{2'b10, 4'd3,  32, 34, 32'h8000_0003, 1'b0};
        vecs[3]  = '{2'b00, 4'd5,  8,  10, 32'h0000_0005, 1'b0};
        vecs[4]  = '{2'b01, 4'd12, 5,  8,  32'h4000_000C, 1'b0};
        vecs[5]  = '{2'b00, 4'd12, 5,  7,  32'h0000_000C, 1'b0};
        vecs[6]  = '{2'b00, 4'd4,  14, 16, 32'h0000_0004, 1'b0};
        vecs[7]  = '{2'b10, 4'd2,  5,  7,  32'h8000_0002, 1'b0};
        vecs[8]  = '{2'b00, 4'd3,  1,  3,  32'h0000_0003, 1'b0};
        vecs[9]  = '{2'b01, 4'd0,  4,  7,  32'h4000_0000, 1'b1};
        vecs[10] = '{2'b10, 4'd0,  4,  6,  32'h8000_0000, 1'b0};

        // Reset state
        @(negedge clock);
        check("rst_instr", bus.coproc_instr, 32'hC000_0000);
        check("rst_outputs", {24'd0, bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last,
                              bus.cmd_done, bus.cmd_err, 2'b00}, 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Table-driven commands, issued back-to-back
        for (int i = 0; i < 11; i++) begin
            run_cmd(i, vecs[i].op, vecs[i].sel, vecs[i].n, vecs[i].done_off,
                    vecs[i].header, vecs[i].gaps);
        end

`ifdef SEQ_ILLEGAL_CHECK_EN
        // op 11 and key sel 9 are refused
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_sel = 4'd9;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        check("op11_err", {31'd0, bus.cmd_err}, 32'd1);
        check("op11_instr", bus.coproc_instr, 32'hC000_0000);
        check("op11_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clock);
        check("op11_err_pulse", {31'd0, bus.cmd_err}, 32'd0);
        check("op11_no_done", {31'd0, bus.cmd_done}, 32'd0);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_sel = 4'd9;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        check("key9_err", {31'd0, bus.cmd_err}, 32'd1);
        check("key9_instr", bus.coproc_instr, 32'hC000_0000);
        @(negedge clock);
        check("key9_err_pulse", {31'd0, bus.cmd_err}, 32'd0);
        check("key9_instr2", bus.coproc_instr, 32'hC000_0000);
`else
        // op 11: one header cycle then DONE
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_sel = 4'd9;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        check("op11_header", bus.coproc_instr, 32'hC000_0009);
        check("op11_err", {31'd0, bus.cmd_err}, 32'd0);
        @(negedge clock);
        check("op11_done", {31'd0, bus.cmd_done}, 32'd1);
        check("op11_instr", bus.coproc_instr, 32'hC000_0000);
        @(negedge clock);
        check("op11_done_pulse", {31'd0, bus.cmd_done}, 32'd0);
        check("op11_ready", {31'd0, bus.cmd_ready}, 32'd1);
        // key sel 9 is issued with a single-word length
        run_cmd(20, 2'b10, 4'd9, 1, 3, 32'h8000_0009, 1'b0);
`endif

        // Reset mid-BURST (cmd_valid held high during LOAD must be ignored)
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_sel = 4'd9;
        @(negedge clock);
        bus.cmd_op = 2'b10; bus.cmd_sel = 4'd3;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = pay(4'd9, i);
            @(negedge clock);
        end
        bus.wr_valid = 1'b0; bus.cmd_valid = 1'b0;
        check("abort_presel", bus.coproc_instr, 32'hC000_0009);
        @(negedge clock);
        check("abort_header", bus.coproc_instr, 32'h4000_0009);
        @(negedge clock);
        check("abort_burst0", bus.coproc_instr, pay(4'd9, 0));
        #2 reset_n = 1'b0;
        #1;
        check("abort_instr", bus.coproc_instr, 32'hC000_0000);
        check("abort_outputs", {26'd0, bus.cmd_ready, bus.wr_ready, bus.rd_valid,
                                bus.cmd_done, bus.cmd_err, 1'b0}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("abort_instr_idle", bus.coproc_instr, 32'hC000_0000);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.cmd_done === 1'b1 || bus.coproc_instr !== 32'hC000_0000) dones++;
        end
        check("abort_quiet", 32'(dones), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
